vga_scan_timing: RTL

- Sole timing source for the room renderers: generates the 640x480@60 Hz raster on clk_vga (25 MHz pixel clock).
- Drives the CurrentX/CurrentY coordinate buses that every room map module samples.
- Takes back the registered 8-bit map colour, aligns sync and blanking to the map pipeline latency, and produces the final VGA pin signals.
- Sits directly upstream (coordinates) and downstream (colour) of the room map modules.

---
 rtl/vga_scan_timing.sv | 74 +++++++
 1 files changed

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: 640x480@60 raster counters, coordinate buses and latency-aligned VGA pin outputs
module vga_scan_timing #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int MAP_LAT = 1
) (
  input  logic       clk_vga,
  input  logic       rst,
  output logic [9:0] CurrentX,
  output logic [8:0] CurrentY,
  input  logic [7:0] mapData,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_start,
  output logic       line_visible
);
  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  logic [9:0] hcnt, vcnt;
  logic vis_raw, hs_raw, vs_raw, h_end;
  logic [MAP_LAT-1:0] vis_sr, hs_sr, vs_sr;
  // pixel and line counters; the line counter only steps at the end of each line
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      hcnt <= h_end ? '0 : hcnt + 10'd1;
      if (h_end) vcnt <= (vcnt == 10'(V_TOT - 1)) ? '0 : vcnt + 10'd1;
    end
  end
  // raw timing decode straight from the counters, plus the unaligned game-logic strobes
  always_comb begin
    h_end        = hcnt == 10'(H_TOT - 1);
    line_visible = vcnt < 10'(V_VIS);
    vis_raw      = (hcnt < 10'(H_VIS)) && line_visible;
    hs_raw       = !((hcnt >= 10'(H_VIS + H_FP)) && (hcnt < 10'(H_VIS + H_FP + H_SYNC)));
    vs_raw       = !((vcnt >= 10'(V_VIS + V_FP)) && (vcnt < 10'(V_VIS + V_FP + V_SYNC)));
    CurrentX     = hcnt;
    CurrentY     = line_visible ? vcnt[8:0] : '0;
    frame_start  = !rst && (hcnt == '0) && (vcnt == '0);
  end
  // delay lines matching the map modules' latency so flags meet mapData for the same pixel
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      vis_sr <= '0;
      hs_sr  <= '1;
      vs_sr  <= '1;
    end else begin
      vis_sr <= MAP_LAT'({vis_sr, vis_raw});
      hs_sr  <= MAP_LAT'({hs_sr, hs_raw});
      vs_sr  <= MAP_LAT'({vs_sr, vs_raw});
    end
  end
  // pin register: colour is blanked outside the visible area so mapData never leaks into porches
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      rgb   <= vis_sr[MAP_LAT-1] ? mapData : '0;
      hsync <= hs_sr[MAP_LAT-1];
      vsync <= vs_sr[MAP_LAT-1];
    end
  end
endmodule
